wave_sample_scheduler: RTL and testbench

- Sequencing controller for the CORDIC waveform generators (sine and square/triangle path).
- Accepts byte-wide configuration writes for phase increment, amplitude and sample-rate divider; holds them in shadow registers.
- Applies them to the generator only at sample boundaries, and issues periodic next-data requests.
- Captures each returned sample into a registered output with a one-cycle valid strobe.
- Sits between the top-level pin decode and the generator instances, replacing direct pin-driven strobes.

---
 rtl/wave_sample_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_wave_sample_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sample_scheduler.sv
// -----------------------------------------------------------------------------
// wave_sample_scheduler
//
// Sequencing controller that sits between the pin decode and the CORDIC
// waveform generators. Configuration writes land in shadow registers and are
// only handed to the generator at sample boundaries. A free-running divider
// paces next-data requests, and each returned sample is captured into data_o
// with a one-cycle valid strobe.
//
// Optional feature (macro WAVE_SCHED_WDOG_EN): a watchdog that bounds
// WAIT_DATA to WDOG_CYCLES cycles after the request strobe and raises a
// sticky error_o when it expires. Without the macro, error_o is tied to 0 and
// WAIT_DATA waits indefinitely.
//
// Ports
//   clk_i                         clock
//   rst_i                         synchronous reset, active-high
//   enable_i                      level, 1 = run periodic sampling
//   cfg_data_i                    configuration write data
//   cfg_phase_we_i                write pending phase
//   cfg_amp_we_i                  write pending amplitude
//   cfg_div_we_i                  write divider (low DIV_WIDTH bits of data)
//   gen_phase_o / _valid_strobe_o phase load to generator
//   gen_amplitude_o / _valid_...  amplitude load to generator
//   gen_next_data_strobe_o        one-cycle sample request
//   gen_data_i / _valid_strobe_i  sample returned by generator
//   data_o / data_valid_strobe_o  captured sample and its strobe
//   busy_o                        1 whenever the FSM is not in IDLE
//   error_o                       sticky watchdog flag
//
// State    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | sampling disabled, waiting for enable_i
// LOAD_PHASE | push pending phase to the generator if one is queued
// LOAD_AMP | push pending amplitude to the generator if one is queued
// WAIT_TICK | waiting for the divider tick
// REQUEST  | next-data strobe is on the output this cycle
// WAIT_DATA | waiting for the generator's sample
// -----------------------------------------------------------------------------
module wave_sample_scheduler #(
  parameter int DATA_WIDTH  = 8,
  parameter int DIV_WIDTH   = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic                  cfg_phase_we_i,
  input  logic                  cfg_amp_we_i,
  input  logic                  cfg_div_we_i,
  output logic [DATA_WIDTH-1:0] gen_phase_o,
  output logic                  gen_phase_valid_strobe_o,
  output logic [DATA_WIDTH-1:0] gen_amplitude_o,
  output logic                  gen_amplitude_valid_strobe_o,
  output logic                  gen_next_data_strobe_o,
  input  logic [DATA_WIDTH-1:0] gen_data_i,
  input  logic                  gen_data_valid_strobe_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_strobe_o,
  output logic                  busy_o,
  output logic                  error_o
);

  // The divider is loaded from the low bits of the config bus, and the
  // watchdog needs at least one WAIT_DATA cycle after REQUEST to count.
  if (DIV_WIDTH > DATA_WIDTH || WDOG_CYCLES < 2) begin : g_bad_params
    $error("wave_sample_scheduler: DIV_WIDTH must be <= DATA_WIDTH and WDOG_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_PHASE,
    S_LOAD_AMP,
    S_WAIT_TICK,
    S_REQUEST,
    S_WAIT_DATA
  } state_t;

  state_t                r_state;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [DATA_WIDTH-1:0] r_phase_pend;
  logic [DATA_WIDTH-1:0] r_amp_pend;
  logic                  r_phase_flag;
  logic                  r_amp_flag;
  logic [DATA_WIDTH-1:0] r_gen_phase;
  logic                  r_gen_phase_stb;
  logic [DATA_WIDTH-1:0] r_gen_amp;
  logic                  r_gen_amp_stb;
  logic                  r_next_stb;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_data_stb;
  logic                  w_tick;

`ifdef WAVE_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_error;
`endif

  // Sample-rate divider: period is r_div+1 cycles. A divider write restarts
  // the count so the new period starts cleanly.
  assign w_tick = enable_i && (r_div_cnt == r_div);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div     <= '0;
      r_div_cnt <= '0;
    end else if (cfg_div_we_i) begin
      r_div     <= cfg_data_i[DIV_WIDTH-1:0];
      r_div_cnt <= '0;
    end else if (enable_i) begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= S_IDLE;
      r_phase_pend    <= '0;
      r_amp_pend      <= '0;
      r_phase_flag    <= 1'b0;
      r_amp_flag      <= 1'b0;
      r_gen_phase     <= '0;
      r_gen_phase_stb <= 1'b0;
      r_gen_amp       <= '0;
      r_gen_amp_stb   <= 1'b0;
      r_next_stb      <= 1'b0;
      r_data          <= '0;
      r_data_stb      <= 1'b0;
`ifdef WAVE_SCHED_WDOG_EN
      r_wdog_cnt      <= '0;
      r_error         <= 1'b0;
`endif
    end else begin
      r_gen_phase_stb <= 1'b0;
      r_gen_amp_stb   <= 1'b0;
      r_next_stb      <= 1'b0;
      r_data_stb      <= 1'b0;
`ifdef WAVE_SCHED_WDOG_EN
      r_wdog_cnt      <= '0;
`endif

      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_state <= (r_phase_flag || r_amp_flag) ? S_LOAD_PHASE : S_WAIT_TICK;
          end
        end

        S_LOAD_PHASE: begin
          if (r_phase_flag) begin
            r_gen_phase     <= r_phase_pend;
            r_gen_phase_stb <= 1'b1;
            r_phase_flag    <= 1'b0;
          end
          r_state <= S_LOAD_AMP;
        end

        S_LOAD_AMP: begin
          if (r_amp_flag) begin
            r_gen_amp     <= r_amp_pend;
            r_gen_amp_stb <= 1'b1;
            r_amp_flag    <= 1'b0;
          end
          r_state <= S_WAIT_TICK;
        end

        S_WAIT_TICK: begin
          if (!enable_i) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            // Strobe is raised with the state change so it lands one cycle
            // after the tick.
            r_next_stb <= 1'b1;
            r_state    <= S_REQUEST;
          end
        end

        S_REQUEST: begin
`ifdef WAVE_SCHED_WDOG_EN
          // Watchdog counts from the request cycle, so it expires exactly
          // WDOG_CYCLES cycles after the strobe.
          r_wdog_cnt <= r_wdog_cnt + 1'b1;
`endif
          r_state <= S_WAIT_DATA;
        end

        S_WAIT_DATA: begin
          if (gen_data_valid_strobe_i) begin
            r_data     <= gen_data_i;
            r_data_stb <= 1'b1;
            r_state    <= (r_phase_flag || r_amp_flag) ? S_LOAD_PHASE : S_WAIT_TICK;
          end
`ifdef WAVE_SCHED_WDOG_EN
          else if (r_wdog_cnt == WDOG_LAST) begin
            r_error <= 1'b1;
            r_state <= S_WAIT_TICK;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
          end
`endif
        end

        default: r_state <= S_IDLE;
      endcase

      // Writes come after the FSM so a write landing in the same cycle as a
      // LOAD state keeps its flag set and is applied at the next boundary.
      if (cfg_phase_we_i) begin
        r_phase_pend <= cfg_data_i;
        r_phase_flag <= 1'b1;
      end
      if (cfg_amp_we_i) begin
        r_amp_pend <= cfg_data_i;
        r_amp_flag <= 1'b1;
      end
    end
  end

  assign gen_phase_o                  = r_gen_phase;
  assign gen_phase_valid_strobe_o     = r_gen_phase_stb;
  assign gen_amplitude_o              = r_gen_amp;
  assign gen_amplitude_valid_strobe_o = r_gen_amp_stb;
  assign gen_next_data_strobe_o       = r_next_stb;
  assign data_o                       = r_data;
  assign data_valid_strobe_o          = r_data_stb;
  assign busy_o                       = (r_state != S_IDLE);

`ifdef WAVE_SCHED_WDOG_EN
  assign error_o = r_error;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_wave_sample_scheduler.sv
// Self-checking bench for wave_sample_scheduler: directed vectors with
// hand-computed expectations, plus a generator model that answers each
// request after a programmable latency and checks the capture timing.
module tb_wave_sample_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b0;
  logic [7:0] cfg_data_i = '0;
  logic       cfg_phase_we_i = 1'b0;
  logic       cfg_amp_we_i = 1'b0;
  logic       cfg_div_we_i = 1'b0;
  logic [7:0] gen_phase_o;
  logic       gen_phase_valid_strobe_o;
  logic [7:0] gen_amplitude_o;
  logic       gen_amplitude_valid_strobe_o;
  logic       gen_next_data_strobe_o;
  logic [7:0] gen_data_i;
  logic       gen_data_valid_strobe_i;
  logic [7:0] data_o;
  logic       data_valid_strobe_o;
  logic       busy_o;
  logic       error_o;

  // generator model and spurious-strobe driver
  int         resp_lat = 2;
  logic       resp_chk = 1'b1;
  logic [7:0] resp_data = 8'hA0;
  logic [7:0] resp_data_d = '0;
  logic       resp_valid = 1'b0;
  logic [7:0] spur_data = '0;
  logic       spur_valid = 1'b0;

  assign gen_data_valid_strobe_i = resp_valid | spur_valid;
  assign gen_data_i = spur_valid ? spur_data : resp_data_d;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  wave_sample_scheduler #(
    .DATA_WIDTH(8),
    .DIV_WIDTH(8),
    .WDOG_CYCLES(64)
  ) dut (
    .clk_i                        (clk_i),
    .rst_i                        (rst_i),
    .enable_i                     (enable_i),
    .cfg_data_i                   (cfg_data_i),
    .cfg_phase_we_i               (cfg_phase_we_i),
    .cfg_amp_we_i                 (cfg_amp_we_i),
    .cfg_div_we_i                 (cfg_div_we_i),
    .gen_phase_o                  (gen_phase_o),
    .gen_phase_valid_strobe_o     (gen_phase_valid_strobe_o),
    .gen_amplitude_o              (gen_amplitude_o),
    .gen_amplitude_valid_strobe_o (gen_amplitude_valid_strobe_o),
    .gen_next_data_strobe_o       (gen_next_data_strobe_o),
    .gen_data_i                   (gen_data_i),
    .gen_data_valid_strobe_i      (gen_data_valid_strobe_i),
    .data_o                       (data_o),
    .data_valid_strobe_o          (data_valid_strobe_o),
    .busy_o                       (busy_o),
    .error_o                      (error_o)
  );

  initial forever #5 clk_i = ~clk_i;
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // which: 0 phase strobe, 1 amp strobe, 2 request, 3 data valid, 4 error
  task automatic wait_sig(input int which, input int max_cyc, input string tag, output int at);
    logic s;
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      case (which)
        0:       s = gen_phase_valid_strobe_o;
        1:       s = gen_amplitude_valid_strobe_o;
        2:       s = gen_next_data_strobe_o;
        3:       s = data_valid_strobe_o;
        default: s = error_o;
      endcase
      if (s === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(at >= 0), 32'd1);
  endtask

  // Generator model: valid is raised resp_lat cycles after the request
  // strobe and held for one cycle; capture must follow on the next cycle.
  initial forever begin
    @(posedge clk_i);
    #2;
    if (gen_next_data_strobe_o === 1'b1 && resp_lat > 0) begin
      repeat (resp_lat) begin
        @(posedge clk_i);
        #2;
      end
      if (resp_chk) chk("cap_early", 32'(data_valid_strobe_o), 32'd0);
      resp_data_d = resp_data;
      resp_valid  = 1'b1;
      @(posedge clk_i);
      #1;
      if (resp_chk) begin
        chk("cap_stb", 32'(data_valid_strobe_o), 32'd1);
        chk("cap_data", 32'(data_o), 32'(resp_data_d));
      end
      #1;
      resp_valid = 1'b0;
    end
  end

  // Strobes never run two cycles; data_o only moves with its strobe.
  initial begin
    logic [3:0] prev_stb;
    logic [3:0] cur_stb;
    logic [7:0] prev_data;
    prev_stb  = '0;
    prev_data = '0;
    forever begin
      @(posedge clk_i);
      #1;
      cur_stb = {gen_phase_valid_strobe_o, gen_amplitude_valid_strobe_o,
                 gen_next_data_strobe_o, data_valid_strobe_o};
      if (!rst_i) begin
        chk("stb_run", 32'(prev_stb & cur_stb), 32'd0);
        if (!data_valid_strobe_o) chk("data_hold", 32'(data_o), 32'(prev_data));
      end
      prev_stb  = cur_stb;
      prev_data = data_o;
    end
  end

  initial begin
    int r0, r1, r2, dv, a, acc, cnt, e;

    // reset then idle
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    chk("rst_vals", 32'({gen_phase_o, gen_amplitude_o, data_o}), 32'd0);
    chk("rst_flags", 32'({gen_phase_valid_strobe_o, gen_amplitude_valid_strobe_o,
                          gen_next_data_strobe_o, data_valid_strobe_o, busy_o, error_o}), 32'd0);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      acc = acc | int'({gen_phase_valid_strobe_o, gen_amplitude_valid_strobe_o,
                        gen_next_data_strobe_o, data_valid_strobe_o, busy_o});
    end
    chk("idle_quiet", 32'(acc), 32'd0);

    // config apply: phase 0x10, amp 0x7F, divider 3
    cfg_data_i = 8'h10; cfg_phase_we_i = 1'b1; step(); cfg_phase_we_i = 1'b0;
    cfg_data_i = 8'h7F; cfg_amp_we_i = 1'b1;   step(); cfg_amp_we_i = 1'b0;
    cfg_data_i = 8'd3;  cfg_div_we_i = 1'b1;   step(); cfg_div_we_i = 1'b0;
    chk("shadow_hold", 32'({busy_o, gen_phase_o}), 32'd0);
    resp_lat = 2; resp_data = 8'hA0;
    enable_i = 1'b1;
    step();
    chk("load_busy", 32'({busy_o, gen_phase_valid_strobe_o}), 32'b10);
    step();
    chk("phase_stb", 32'({gen_phase_valid_strobe_o, gen_phase_o}), 32'h110);
    step();
    chk("amp_stb", 32'({gen_phase_valid_strobe_o, gen_amplitude_valid_strobe_o, gen_amplitude_o}),
        32'h17F);
    wait_sig(2, 20, "req0", r0);
    wait_sig(2, 20, "req1", r1);
    chk("period4_a", 32'(r1 - r0), 32'd4);
    wait_sig(2, 20, "req2", r2);
    chk("period4_b", 32'(r2 - r1), 32'd4);

    // sample capture with 3-cycle response; tick during WAIT_DATA is dropped
    wait_sig(3, 10, "dv2", dv);
    resp_lat = 3; resp_data = 8'h5A;
    wait_sig(2, 20, "req3", r0);
    wait_sig(2, 20, "req4", r1);
    chk("period8", 32'(r1 - r0), 32'd8);
    chk("cap_5a", 32'(data_o), 32'h5A);

    // amplitude write during WAIT_DATA is held until the sample completes
    step();
    cfg_data_i = 8'h40; cfg_amp_we_i = 1'b1; step(); cfg_amp_we_i = 1'b0;
    chk("amp_deferred", 32'({gen_amplitude_valid_strobe_o, gen_amplitude_o}), 32'h07F);
    wait_sig(3, 10, "dv4", dv);
    wait_sig(1, 10, "amp40", a);
    chk("amp40_val", 32'(gen_amplitude_o), 32'h40);
    chk("amp_after_data", 32'(a - dv), 32'd2);
    resp_data = 8'h33;
    wait_sig(2, 20, "req5", r2);
    chk("amp_before_req", 32'(r2 - a), 32'd2);

    // disable mid-sample, then spurious valid in IDLE
    step();
    enable_i = 1'b0;
    wait_sig(3, 10, "dv5", dv);
    chk("busy_at_dv", 32'(busy_o), 32'd1);
    step();
    chk("busy_fall", 32'(busy_o), 32'd0);
    chk("dis_data", 32'(data_o), 32'h33);
    spur_data = 8'hEE; spur_valid = 1'b1; step(); spur_valid = 1'b0;
    step();
    chk("spur_ignored", 32'({data_valid_strobe_o, busy_o, data_o}), 32'h033);

    // phase write colliding with LOAD_PHASE: old value loads, new one next
    cfg_data_i = 8'h21; cfg_phase_we_i = 1'b1; step(); cfg_phase_we_i = 1'b0;
    resp_lat = 2; resp_data = 8'h44;
    enable_i = 1'b1;
    step();
    cfg_data_i = 8'h22; cfg_phase_we_i = 1'b1; step(); cfg_phase_we_i = 1'b0;
    chk("collide_old", 32'({gen_phase_valid_strobe_o, gen_phase_o}), 32'h121);
    wait_sig(0, 40, "collide_new", a);
    chk("collide_new_val", 32'(gen_phase_o), 32'h22);

    // reset in the middle of WAIT_DATA
    wait_sig(2, 20, "req_rst", r0);
    step();
    resp_chk = 1'b0;
    rst_i = 1'b1; enable_i = 1'b0;
    step();
    chk("midrst_vals", 32'({gen_phase_o, gen_amplitude_o, data_o}), 32'd0);
    chk("midrst_flags", 32'({gen_phase_valid_strobe_o, gen_amplitude_valid_strobe_o,
                             gen_next_data_strobe_o, data_valid_strobe_o, busy_o, error_o}), 32'd0);
    step();
    rst_i = 1'b0;
    repeat (6) step();
    resp_chk = 1'b1;

    // generator never answers
    cfg_data_i = 8'd3; cfg_div_we_i = 1'b1; step(); cfg_div_we_i = 1'b0;
    resp_lat = 0;
    enable_i = 1'b1;
    wait_sig(2, 20, "req_wd", r0);
`ifdef WAVE_SCHED_WDOG_EN
    wait_sig(4, 100, "wdog_err", e);
    chk("wdog_delay", 32'(e - r0), 32'd64);
    chk("wdog_data", 32'(data_o), 32'd0);
    wait_sig(2, 20, "req_after_wd", r1);
    chk("wdog_next_req", 32'(r1 - e), 32'd4);
    chk("wdog_sticky", 32'(error_o), 32'd1);
`else
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (gen_next_data_strobe_o) cnt++;
    end
    chk("hang_no_req", 32'(cnt), 32'd0);
    chk("hang_state", 32'({busy_o, error_o}), 32'b10);
`endif

    enable_i = 1'b0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
